// File: rtl/pla_pkg.sv
// Shared definitions for the PLA term engine: cube-pair encoding and FSM states.
package pla_pkg;

  // Two bits per input select which input values a product term accepts.
  localparam logic [1:0] CUBE_NULL = 2'b00;
  localparam logic [1:0] CUBE_ZERO = 2'b01;
  localparam logic [1:0] CUBE_ONE  = 2'b10;
  localparam logic [1:0] CUBE_DC   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pla_cube_match.sv
// Tests one product term (cube + enable) against an input vector.
module pla_cube_match
  import pla_pkg::*;
#(
  parameter int N_IN = 8
) (
  input  logic [2*N_IN-1:0] cube_i,
  input  logic              en_i,
  input  logic [N_IN-1:0]   x_i,
  output logic              match_o
);

  logic allLitOk;

  // Every literal must accept its input bit; a null pair rejects both values.
  always_comb begin
    allLitOk = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      case (cube_i[2*i +: 2])
        CUBE_DC:   allLitOk = allLitOk;
        CUBE_ONE:  allLitOk = allLitOk & x_i[i];
        CUBE_ZERO: allLitOk = allLitOk & ~x_i[i];
        default:   allLitOk = 1'b0;
      endcase
    end
  end

  assign match_o = en_i & allLitOk;

endmodule

// File: rtl/pla_term_engine.sv
// Multi-cycle PLA evaluator: a table of product terms is scanned LANES terms
// per cycle and the output masks of matching terms are OR-ed into z.
// Optional feature macro: PLA_TERM_ENGINE_HITCNT_EN adds the hit_cnt output.
module pla_term_engine
  import pla_pkg::*;
#(
  parameter int N_IN    = 8,
  parameter int N_OUT   = 18,
  parameter int N_TERMS = 64,
  parameter int LANES   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [$clog2(N_TERMS)-1:0] cfg_addr,
  input  logic [2*N_IN-1:0]          cfg_cube,
  input  logic [N_OUT-1:0]           cfg_outs,
  input  logic                       cfg_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN-1:0]            x,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_OUT-1:0]           z
`ifdef PLA_TERM_ENGINE_HITCNT_EN
  ,
  output logic [$clog2(N_TERMS+1)-1:0] hit_cnt
`endif
);

  localparam int AW = $clog2(N_TERMS);

  if (N_TERMS % LANES != 0) begin : gBadLanes
    $error("pla_term_engine: N_TERMS must be a multiple of LANES");
  end

  state_t state_q, state_d;

  logic [2*N_IN-1:0] cubeMem [N_TERMS];
  logic [N_OUT-1:0]  outsMem [N_TERMS];
  logic [N_TERMS-1:0] termEn_q;

  logic [AW-1:0]    termPtr_q;
  logic [N_OUT-1:0] acc_q, acc_d;
  logic [N_OUT-1:0] z_q;
  logic [N_IN-1:0]  xLatch_q;

  logic [LANES-1:0] laneMatch;
  logic [N_OUT-1:0] laneOuts [LANES];
  logic             cfgWe;
  logic             lastStep;

  // Table writes are only accepted while idle, so an evaluation always sees a frozen table.
  assign cfgWe     = cfg_valid && (state_q == IDLE);
  assign lastStep  = (termPtr_q == AW'(N_TERMS - LANES));
  assign in_ready  = (state_q == IDLE);
  assign cfg_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign z         = z_q;

  // Cube and mask storage carry no reset; a term is harmless until its enable is set.
  always_ff @(posedge clk) begin
    if (cfgWe) begin
      cubeMem[cfg_addr] <= cfg_cube;
      outsMem[cfg_addr] <= cfg_outs;
    end
  end

  // Enable bits are cleared on reset so a freshly reset engine matches nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      termEn_q <= '0;
    end else if (cfgWe) begin
      termEn_q[cfg_addr] <= cfg_en;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : gLane
    logic [AW-1:0] laneIdx;
    assign laneIdx     = termPtr_q + AW'(l);
    assign laneOuts[l] = outsMem[laneIdx];

    pla_cube_match #(
      .N_IN(N_IN)
    ) uMatch (
      .cube_i (cubeMem[laneIdx]),
      .en_i   (termEn_q[laneIdx]),
      .x_i    (xLatch_q),
      .match_o(laneMatch[l])
    );
  end

  // Fold this cycle's matching lane masks into the running OR.
  always_comb begin
    acc_d = acc_q;
    for (int l = 0; l < LANES; l++) begin
      if (laneMatch[l]) begin
        acc_d = acc_d | laneOuts[l];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept, scan the table, then hold the result until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EVAL;
      EVAL:    if (lastStep) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the vector on accept, accumulate while scanning, publish on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      termPtr_q <= '0;
      acc_q     <= '0;
      z_q       <= '0;
      xLatch_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            xLatch_q  <= x;
            termPtr_q <= '0;
            acc_q     <= '0;
          end
        end
        EVAL: begin
          acc_q     <= acc_d;
          termPtr_q <= termPtr_q + AW'(LANES);
          if (lastStep) begin
            z_q <= acc_d;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PLA_TERM_ENGINE_HITCNT_EN
  localparam int HW = $clog2(N_TERMS + 1);

  logic [HW-1:0] hitAcc_q, hitAcc_d;
  logic [HW-1:0] hitCnt_q;

  // Count matching lanes this cycle on top of the running total.
  always_comb begin
    hitAcc_d = hitAcc_q;
    for (int l = 0; l < LANES; l++) begin
      if (laneMatch[l]) begin
        hitAcc_d = hitAcc_d + HW'(1);
      end
    end
  end

  // Hit counter follows the same accept/scan/publish rhythm as z.
  always_ff @(posedge clk) begin
    if (rst) begin
      hitAcc_q <= '0;
      hitCnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            hitAcc_q <= '0;
          end
        end
        EVAL: begin
          hitAcc_q <= hitAcc_d;
          if (lastStep) begin
            hitCnt_q <= hitAcc_d;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign hit_cnt = hitCnt_q;
`endif

endmodule

// File: tb/tb_pla_term_engine.sv
// Self-checking bench for pla_term_engine: directed scenarios followed by a
// random full-table sweep against a behavioural two-level PLA model.
module tb_pla_term_engine;

  localparam int N_IN    = 8;
  localparam int N_OUT   = 18;
  localparam int N_TERMS = 64;
  localparam int LANES   = 4;
  localparam int LAT     = N_TERMS / LANES + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [5:0]        cfg_addr;
  logic [2*N_IN-1:0] cfg_cube;
  logic [N_OUT-1:0]  cfg_outs;
  logic              cfg_en;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   x;
  logic              out_valid;
  logic              out_ready;
  logic [N_OUT-1:0]  z;
`ifdef PLA_TERM_ENGINE_HITCNT_EN
  logic [6:0]        hit_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [2*N_IN-1:0] mCube [N_TERMS];
  logic [N_OUT-1:0]  mOuts [N_TERMS];
  bit                mEn   [N_TERMS];

  pla_term_engine #(
    .N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS), .LANES(LANES)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_cube(cfg_cube), .cfg_outs(cfg_outs), .cfg_en(cfg_en),
    .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .z(z)
`ifdef PLA_TERM_ENGINE_HITCNT_EN
    , .hit_cnt(hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Golden model: a term fires when enabled and every pair has the bit for x[i] set.
  task automatic modelEval(input logic [N_IN-1:0] xv, output logic [N_OUT-1:0] zz, output int hits);
    logic [1:0] pair;
    bit ok;
    zz = '0;
    hits = 0;
    for (int t = 0; t < N_TERMS; t++) begin
      ok = mEn[t];
      for (int i = 0; i < N_IN; i++) begin
        pair = mCube[t][2*i +: 2];
        if (pair[xv[i]] == 1'b0) ok = 1'b0;
      end
      if (ok) begin
        zz = zz | mOuts[t];
        hits++;
      end
    end
  endtask

  // Called right after a falling edge; writes one term while the engine idles.
  task automatic writeTerm(input int addr, input logic [15:0] cube, input logic [17:0] outs, input bit en);
    cfg_valid = 1'b1;
    cfg_addr  = 6'(addr);
    cfg_cube  = cube;
    cfg_outs  = outs;
    cfg_en    = en;
    checkOutput("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    mCube[addr] = cube;
    mOuts[addr] = outs;
    mEn[addr]   = en;
  endtask

  // Runs one evaluation; optionally stalls in DONE with a cfg write that must be ignored.
  task automatic applyStimulus(input logic [7:0] xv, input logic [17:0] expZ, input int expHits, input int hold);
    int cyc;
    x = xv;
    in_valid = 1'b1;
    checkOutput("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
    cyc = 1;
    checkOutput("in_ready_eval", {31'd0, in_ready}, 32'd0);
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("latency", cyc, LAT);
    if (out_valid) begin
      checkOutput("z", {14'd0, z}, {14'd0, expZ});
`ifdef PLA_TERM_ENGINE_HITCNT_EN
      checkOutput("hit_cnt", {25'd0, hit_cnt}, expHits);
`endif
      checkOutput("cfg_ready_done", {31'd0, cfg_ready}, 32'd0);
      if (hold > 0) begin
        cfg_valid = 1'b1;
        cfg_addr  = 6'd0;
        cfg_cube  = 16'h0000;
        cfg_outs  = 18'h0;
        cfg_en    = 1'b0;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          checkOutput("z_hold", {14'd0, z}, {14'd0, expZ});
          checkOutput("out_valid_hold", {31'd0, out_valid}, 32'd1);
          checkOutput("in_ready_done", {31'd0, in_ready}, 32'd0);
        end
        cfg_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("out_valid_drop", {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [N_OUT-1:0] zz;
    int hits;
    bit seen;
    logic [15:0] rc;
    logic [17:0] ro;
    int r;

    rst = 1'b1;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_cube = '0; cfg_outs = '0; cfg_en = 1'b0;
    in_valid = 1'b0; x = '0; out_ready = 1'b0;
    for (int t = 0; t < N_TERMS; t++) begin
      mCube[t] = 16'hFFFF; mOuts[t] = '0; mEn[t] = 1'b0;
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_z", {14'd0, z}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Empty table gives all-zero output.
    applyStimulus(8'h5A, 18'h0, 0, 0);

    // Single term: x0 must be 1, x1 must be 0.
    writeTerm(0, 16'hFFF6, 18'h01000, 1'b1);
    applyStimulus(8'h01, 18'h01000, 1, 0);
    applyStimulus(8'h03, 18'h00000, 0, 0);
    applyStimulus(8'h05, 18'h01000, 1, 0);

    // Overlapping masks from two always-matching terms.
    writeTerm(5, 16'hFFFF, 18'h00003, 1'b1);
    writeTerm(9, 16'hFFFF, 18'h00006, 1'b1);
    applyStimulus(8'h03, 18'h00007, 2, 0);

    // A null pair and a disabled term never contribute.
    writeTerm(10, 16'hFF3F, 18'h3FFFF, 1'b1);
    writeTerm(11, 16'hFFFF, 18'h08000, 1'b0);
    applyStimulus(8'h03, 18'h00007, 2, 0);
    applyStimulus(8'h01, 18'h01007, 3, 0);

    // Overwrite term 9 completely.
    writeTerm(9, 16'hFFF6, 18'h20000, 1'b1);
    applyStimulus(8'h03, 18'h00003, 1, 0);
    applyStimulus(8'h01, 18'h21003, 3, 0);

    // Term write and evaluation accepted on the same idle cycle.
    cfg_valid = 1'b1; cfg_addr = 6'd20; cfg_cube = 16'hFFFF; cfg_outs = 18'h00100; cfg_en = 1'b1;
    mCube[20] = 16'hFFFF; mOuts[20] = 18'h00100; mEn[20] = 1'b1;
    applyStimulus(8'h03, 18'h00103, 2, 0);

    // Stall in DONE; the attempted disable of term 0 there must not land.
    applyStimulus(8'h03, 18'h00103, 2, 5);
    applyStimulus(8'h01, 18'h21103, 4, 0);

    // Reset mid-evaluation aborts and clears every enable.
    x = 8'h01;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < N_TERMS; t++) mEn[t] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkOutput("abort_no_out_valid", {31'd0, seen}, 32'd0);
    checkOutput("abort_z", {14'd0, z}, 32'd0);
    applyStimulus(8'h01, 18'h0, 0, 0);

    // Random full table and exhaustive sweep against the model.
    for (int t = 0; t < N_TERMS; t++) begin
      for (int i = 0; i < N_IN; i++) begin
        r = $urandom_range(0, 19);
        if (r == 0)      rc[2*i +: 2] = 2'b00;
        else if (r < 5)  rc[2*i +: 2] = 2'b01;
        else if (r < 9)  rc[2*i +: 2] = 2'b10;
        else             rc[2*i +: 2] = 2'b11;
      end
      ro = '0;
      ro[$urandom_range(0, N_OUT-1)] = 1'b1;
      ro[$urandom_range(0, N_OUT-1)] = 1'b1;
      writeTerm(t, rc, ro, $urandom_range(0, 4) != 0);
    end
    for (int v = 0; v < 256; v++) begin
      modelEval(8'(v), zz, hits);
      applyStimulus(8'(v), zz, hits, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
